// File: rtl/ssc_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ssc_tx (with helper ssc_sine_lut)
//  Purpose  : Spread-spectrum test-signal generator. A carrier DDS addresses
//             a quarter-wave sine table, and the sign is flipped by the
//             current PRN chip. The PRN LFSR (hob/poly/val format) is stepped
//             whenever the chip DDS phase MSB rises. Samples leave through a
//             3-stage pipeline as a 16-bit value plus a one-cycle push strobe.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1   system clock
//    rst      in   1   asynchronous, active-low reset
//    addr     in  32   register address, [15:0] decoded
//    Wdata    in  32   write data
//    write    in   1   single-cycle write strobe
//    read     in   1   read strobe (Rdata is 0 when low)
//    Rdata    out 32   combinational read data
//    ADC      out 16   signed sample, registered, held between strobes
//    pushADC  out  1   one-cycle strobe, ADC valid
//    busy     out  1   a sample is somewhere in the pipeline
// ============================================================================

// Quarter-wave sine table: a parabolic fit a*(2N-a), with N = 2**SINE_AW.
// It reaches exactly 0x7FFF at the last address and is monotonic rising.
module ssc_sine_lut #(
  parameter int SINE_AW = 13
) (
  input  logic [SINE_AW-1:0] addr,
  output logic [15:0]        data
);
  localparam int PW = 2 * SINE_AW + 2;

  logic [PW-1:0] a_ext;
  logic [PW-1:0] prod;

  assign a_ext = PW'(addr);
  assign prod  = a_ext * ((PW'(1) << (SINE_AW + 1)) - a_ext);
  assign data  = 16'(prod >> (2 * SINE_AW - 15));
endmodule

module ssc_tx #(
  parameter int PERIOD_W = 16,
  parameter int SINE_AW  = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] Wdata,
  input  logic        write,
  input  logic        read,
  output logic [31:0] Rdata,
  output logic [15:0] ADC,
  output logic        pushADC,
  output logic        busy
);
  localparam logic [15:0] A_RUN    = 16'h0100;
  localparam logic [15:0] A_COUNT  = 16'h0104;
  localparam logic [15:0] A_CADD   = 16'h03A0;
  localparam logic [15:0] A_CPHASE = 16'h03A4;
  localparam logic [15:0] A_CTRL   = 16'h03A8;
  localparam logic [15:0] A_PERIOD = 16'h03AC;
  localparam logic [15:0] A_CHFREQ = 16'h05A0;
  localparam logic [15:0] A_CHPH   = 16'h05A4;
  localparam logic [15:0] A_PRN    = 16'h05A8;

  // Register file
  logic                run;
  logic [31:0]         sample_count;
  logic [31:0]         carrier_add;
  logic [31:0]         carrier_phase;
  logic                enable;
  logic [3:0]          atten;
  logic [PERIOD_W-1:0] period;
  logic [31:0]         chip_freq;
  logic [31:0]         chip_phase;
  logic [3:0]          hob;
  logic [13:0]         poly;
  logic [13:0]         val;

  // Tick generation
  logic [PERIOD_W-1:0] cnt;
  logic                active;
  logic                tick;

  // Pipeline
  logic                s1_valid;
  logic [15:0]         s1_mag;
  logic                s1_quad_hi;
  logic                s1_sign;
  logic                s2_valid;
  logic [15:0]         s2_data;

  logic                unused_addr_hi;
  assign unused_addr_hi = ^addr[31:16];

  // Write decode
  logic wr_run, wr_cadd, wr_cphase, wr_ctrl, wr_period, wr_chfreq, wr_chph, wr_prn;
  assign wr_run    = write && (addr[15:0] == A_RUN);
  assign wr_cadd   = write && (addr[15:0] == A_CADD);
  assign wr_cphase = write && (addr[15:0] == A_CPHASE);
  assign wr_ctrl   = write && (addr[15:0] == A_CTRL);
  assign wr_period = write && (addr[15:0] == A_PERIOD);
  assign wr_chfreq = write && (addr[15:0] == A_CHFREQ);
  assign wr_chph   = write && (addr[15:0] == A_CHPH);
  assign wr_prn    = write && (addr[15:0] == A_PRN);

  assign active = run & enable;
  assign tick   = active && (cnt == period);

  // Carrier lookup from the pre-update phase; odd quadrants mirror the address.
  logic [1:0]         quad;
  logic [SINE_AW-1:0] lut_addr;
  logic [15:0]        lut_data;

  assign quad     = carrier_phase[31:30];
  assign lut_addr = quad[0] ? ~carrier_phase[29:30-SINE_AW] : carrier_phase[29:30-SINE_AW];

  ssc_sine_lut #(.SINE_AW(SINE_AW)) u_lut (
    .addr (lut_addr),
    .data (lut_data)
  );

  // Chip DDS and PRN stepping. A step only counts when the tick itself
  // produced the 0->1 MSB transition, so a bus write to Chip_Phase in the
  // same cycle suppresses it.
  logic [31:0] chip_phase_nxt;
  logic        chip_sign;
  logic        chip_step;

  assign chip_phase_nxt = chip_phase + chip_freq;
  assign chip_sign      = (hob < 4'd14) ? val[hob] : 1'b0;
  assign chip_step      = tick && !wr_chph && !chip_phase[31] && chip_phase_nxt[31];

  function automatic logic [13:0] lfsr_step(input logic [3:0]  h,
                                            input logic [13:0] p,
                                            input logic [13:0] v_in);
    logic [13:0] v;
    logic        x;
    v = v_in;
    x = 1'b0;
    if (h < 4'd14) begin
      x    = v[h];
      v[h] = 1'b0;
    end
    v = v << 1;
    if (x) v = v ^ p;
    return v;
  endfunction

  // Stage-2 negation; the most negative code saturates instead of wrapping.
  logic        s1_negate;
  logic [15:0] s1_neg_val;
  logic [15:0] s2_shifted;

  assign s1_negate  = s1_quad_hi ^ s1_sign;
  assign s1_neg_val = (s1_mag == 16'h8000) ? 16'h7FFF : (~s1_mag + 16'd1);
  assign s2_shifted = 16'($signed(s2_data) >>> atten);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run           <= 1'b0;
      sample_count  <= '0;
      carrier_add   <= '0;
      carrier_phase <= '0;
      enable        <= 1'b0;
      atten         <= '0;
      period        <= '0;
      chip_freq     <= '0;
      chip_phase    <= '0;
      hob           <= '0;
      poly          <= '0;
      val           <= '0;
      cnt           <= '0;
      s1_valid      <= 1'b0;
      s1_mag        <= '0;
      s1_quad_hi    <= 1'b0;
      s1_sign       <= 1'b0;
      s2_valid      <= 1'b0;
      s2_data       <= '0;
      ADC           <= '0;
      pushADC       <= 1'b0;
    end else begin
      if (active) cnt <= tick ? '0 : cnt + PERIOD_W'(1);
      else        cnt <= '0;

      if (wr_run)  run         <= Wdata[0];
      if (wr_cadd) carrier_add <= Wdata;
      if (wr_ctrl) begin
        enable <= Wdata[0];
        atten  <= Wdata[4:1];
      end
      if (wr_period) period    <= Wdata[PERIOD_W-1:0];
      if (wr_chfreq) chip_freq <= Wdata;

      // Bus writes take priority over the tick-side update of the same register.
      if (wr_cphase) carrier_phase <= Wdata;
      else if (tick) carrier_phase <= carrier_phase + carrier_add;

      if (wr_chph)   chip_phase <= Wdata;
      else if (tick) chip_phase <= chip_phase_nxt;

      if (wr_prn) begin
        hob  <= Wdata[31:28];
        poly <= Wdata[27:14];
        val  <= Wdata[13:0];
      end else if (chip_step) begin
        val <= lfsr_step(hob, poly, val);
      end

      s1_valid <= tick;
      if (tick) begin
        s1_mag     <= lut_data;
        s1_quad_hi <= quad[1];
        s1_sign    <= chip_sign;
      end

      s2_valid <= s1_valid;
      if (s1_valid) s2_data <= s1_negate ? s1_neg_val : s1_mag;

      pushADC <= s2_valid;
      if (s2_valid) ADC <= s2_shifted;

      if (pushADC) sample_count <= sample_count + 32'd1;
    end
  end

  assign busy = s1_valid | s2_valid | pushADC;

  always_comb begin
    Rdata = '0;
    if (read) begin
      case (addr[15:0])
        A_RUN:    Rdata = {31'b0, run};
        A_COUNT:  Rdata = sample_count;
        A_CADD:   Rdata = carrier_add;
        A_CPHASE: Rdata = carrier_phase;
        A_CTRL:   Rdata = {27'b0, atten, enable};
        A_PERIOD: Rdata = 32'(period);
        A_CHFREQ: Rdata = chip_freq;
        A_CHPH:   Rdata = chip_phase;
        A_PRN:    Rdata = {hob, poly, val};
        default:  Rdata = '0;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_ssc_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ssc_tx
//  Purpose  : Scoreboard bench for ssc_tx. Each burst predicts its samples
//             (value and strobe cycle) from the carrier/chip arithmetic and
//             queues them; an independent monitor pops on every pushADC.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ssc_tx;
  localparam logic [31:0] A_RUN    = 32'h0100;
  localparam logic [31:0] A_COUNT  = 32'h0104;
  localparam logic [31:0] A_CADD   = 32'h03A0;
  localparam logic [31:0] A_CPHASE = 32'h03A4;
  localparam logic [31:0] A_CTRL   = 32'h03A8;
  localparam logic [31:0] A_PERIOD = 32'h03AC;
  localparam logic [31:0] A_CHFREQ = 32'h05A0;
  localparam logic [31:0] A_CHPH   = 32'h05A4;
  localparam logic [31:0] A_PRN    = 32'h05A8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, Wdata, Rdata;
  logic        write, read;
  logic [15:0] ADC;
  logic        pushADC, busy;

  always #5 clk = ~clk;

  ssc_tx #(.PERIOD_W(16), .SINE_AW(13)) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .Wdata   (Wdata),
    .write   (write),
    .read    (read),
    .Rdata   (Rdata),
    .ADC     (ADC),
    .pushADC (pushADC),
    .busy    (busy)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] adc;
    int unsigned at;
  } exp_t;
  exp_t sbq[$];

  // Reference model state
  logic [31:0] m_add, m_phase, m_cf, m_cp, m_count;
  logic [3:0]  m_atten;
  int          m_hob;
  logic [13:0] m_poly, m_val;
  int          m_period;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b1 && pushADC === 1'b1) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_push: ADC=0x%04h at cycle %0d, none expected", ADC, cyc);
      end else begin
        e = sbq.pop_front();
        check("adc_value", {16'b0, ADC}, {16'b0, e.adc});
        check("push_cycle", cyc, e.at);
      end
    end
  end

  // Sine magnitude by quadrant: parabolic quarter wave, mirrored in odd
  // quadrants, negative in the lower half-cycle, flipped by the chip.
  function automatic logic [15:0] ref_sample(input logic [31:0] ph, input bit sign,
                                             input logic [3:0] att);
    int q, a, mag, v;
    q = int'(ph[31:30]);
    a = int'(ph[29:17]);
    if (q % 2 == 1) a = 8191 - a;
    mag = (a * (16384 - a)) / 2048;
    v = (((q / 2) % 2 == 1) ^ sign) ? -mag : mag;
    v = v >>> att;
    return v[15:0];
  endfunction

  function automatic logic [13:0] lfsr_ref(input int h, input logic [13:0] p,
                                           input logic [13:0] vin);
    int v;
    bit x;
    v = int'(vin);
    x = (h < 14) && (((v >> h) & 1) == 1);
    if (x) v = v - (1 << h);
    v = (v * 2) % 16384;
    if (x) v = v ^ int'(p);
    return v[13:0];
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    Wdata = d;
    write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    read = 1'b1;
    #1;
    d = Rdata;
    read = 1'b0;
  endtask

  task automatic cfg(input logic [31:0] add, input logic [31:0] ph, input logic [3:0] att,
                     input int p, input logic [31:0] cf, input logic [31:0] cp,
                     input int h, input logic [13:0] pl, input logic [13:0] v);
    bus_write(A_CADD, add);
    bus_write(A_CPHASE, ph);
    bus_write(A_CTRL, {27'b0, att, 1'b1});
    bus_write(A_PERIOD, 32'(p));
    bus_write(A_CHFREQ, cf);
    bus_write(A_CHPH, cp);
    bus_write(A_PRN, {h[3:0], pl, v});
    m_add = add; m_phase = ph; m_atten = att; m_period = p;
    m_cf = cf; m_cp = cp; m_hob = h; m_poly = pl; m_val = v;
  endtask

  // Predict one tick: queue the sample, then advance phases and the PRN.
  task automatic model_tick(input int unsigned push_at);
    exp_t        e;
    bit          s;
    logic [31:0] cpn;
    s = (m_hob < 14) ? m_val[m_hob] : 1'b0;
    e.adc = ref_sample(m_phase, s, m_atten);
    e.at  = push_at;
    sbq.push_back(e);
    cpn = m_cp + m_cf;
    if (!m_cp[31] && cpn[31]) m_val = lfsr_ref(m_hob, m_poly, m_val);
    m_cp = cpn;
    m_phase = m_phase + m_add;
  endtask

  task automatic drain_and_check(input int n);
    logic [31:0] d;
    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d samples still expected, required 0", sbq.size());
      sbq.delete();
    end
    repeat (6) @(negedge clk);   // any stray strobe here is flagged by the monitor
    m_count = m_count + 32'(n);
    check("busy_idle", {31'b0, busy}, 32'd0);
    bus_read(A_CPHASE, d); check("carrier_phase_rb", d, m_phase);
    bus_read(A_CHPH, d);   check("chip_phase_rb", d, m_cp);
    bus_read(A_PRN, d);    check("prn_rb", d, {m_hob[3:0], m_poly, m_val});
    bus_read(A_COUNT, d);  check("sample_count", d, m_count);
  endtask

  // Run exactly n ticks at the configured period, then stop.
  task automatic run_burst(input int n, input bit stop_by_ctl);
    int unsigned c1;
    c1 = cyc + 1;   // first cycle with the run bit set
    for (int k = 0; k < n; k++)
      model_tick(c1 + 32'(m_period) + 32'(k * (m_period + 1)) + 3);
    bus_write(A_RUN, 32'd1);
    repeat (n * (m_period + 1) - 1) @(negedge clk);
    if (stop_by_ctl) bus_write(A_CTRL, {27'b0, m_atten, 1'b0});
    else             bus_write(A_RUN, 32'd0);
    bus_write(A_RUN, 32'd0);
    drain_and_check(n);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] d;
    int unsigned c1;
    logic [31:0] mapped[9];
    mapped = '{A_RUN, A_COUNT, A_CADD, A_CPHASE, A_CTRL, A_PERIOD, A_CHFREQ, A_CHPH, A_PRN};
    addr = '0; Wdata = '0; write = 1'b0; read = 1'b0;
    m_count = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_adc", {16'b0, ADC}, 32'd0);
    check("rst_push", {31'b0, pushADC}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    foreach (mapped[i]) begin
      bus_read(mapped[i], d);
      check("rst_reg", d, 32'd0);
    end

    // Enabled but Global_Run low: the monitor flags any strobe here.
    bus_write(A_CTRL, 32'd1);
    repeat (10) @(negedge clk);

    // Quadrant walk with no spreading.
    cfg(32'h4000_0000, 32'h0, 4'd0, 0, 32'h0, 32'h0, 0, 14'h0, 14'h0);
    run_burst(4, 1'b0);
    bus_read(32'h0000_0200, d); check("unmapped_read", d, 32'd0);
    addr = A_CADD; read = 1'b0; #1; check("read_low", Rdata, 32'd0);
    bus_write(A_COUNT, 32'hDEAD_BEEF);
    bus_read(A_COUNT, d); check("count_ro", d, m_count);
    bus_read(A_CTRL, d);  check("ctrl_rb", d, 32'd1);

    // One sample per 5 cycles.
    cfg(32'h1357_9BDF, 32'h0800_0000, 4'd0, 4, 32'h0, 32'h0, 0, 14'h0, 14'h0);
    run_burst(3, 1'b0);

    // PRN stepping every second tick, sign follows val[3].
    cfg(32'h0321_0000, 32'h1000_0000, 4'd0, 0, 32'h8000_0000, 32'h0, 3, 14'd9, 14'd1);
    run_burst(12, 1'b0);

    // Attenuation of full scale, both signs.
    cfg(32'h0, 32'h3FFE_0000, 4'd15, 1, 32'h0, 32'h0, 0, 14'h0, 14'h0);
    run_burst(2, 1'b0);
    cfg(32'h0, 32'hBFFE_0000, 4'd15, 0, 32'h0, 32'h0, 0, 14'h0, 14'h0);
    run_burst(2, 1'b1);

    // Carrier_Phase write collides with the tick: the written value wins.
    cfg(32'h0100_0000, 32'h2000_0000, 4'd0, 3, 32'h9000_0000, 32'h7800_0000, 2, 14'h5, 14'h4);
    c1 = cyc + 1;
    model_tick(c1 + 3 + 3);
    m_phase = 32'h0000_1234;
    bus_write(A_RUN, 32'd1);
    repeat (3) @(negedge clk);
    bus_write(A_CPHASE, 32'h0000_1234);
    bus_write(A_RUN, 32'd0);
    drain_and_check(1);

    // Randomized bursts.
    for (int it = 0; it < 12; it++) begin
      logic [31:0] cf;
      case ($urandom_range(0, 2))
        0:       cf = 32'h8000_0000;
        1:       cf = 32'h4000_0000;
        default: cf = $urandom;
      endcase
      cfg($urandom, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 4)), cf,
          $urandom, int'($urandom_range(0, 15)), 14'($urandom), 14'($urandom));
      run_burst(int'($urandom_range(1, 10)), 1'($urandom_range(0, 1)));
    end

    // Reset while samples are in flight: nothing may come out afterwards.
    cfg(32'h0400_0000, 32'h4000_0000, 4'd0, 0, 32'h0, 32'h0, 0, 14'h0, 14'h0);
    bus_write(A_RUN, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_push", {31'b0, pushADC}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    bus_read(A_COUNT, d);  check("midrst_count", d, 32'd0);
    bus_read(A_CPHASE, d); check("midrst_phase", d, 32'd0);
    check("midrst_adc", {16'b0, ADC}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
